// File: rtl/arbitrated_channel_mux_pkg.sv
// Shared constants and types for the arbitrated channel mux.
package arbitrated_channel_mux_pkg;

    localparam int unsigned CHAN_FIFO_DEPTH = 2;

    typedef logic [1:0] fifo_cnt_t;

endpackage

// File: rtl/arbitrated_channel_mux_fifo.sv
// chan_fifo2: two-entry register FIFO for one producer channel.
// Entry 0 is always the head. Push is ignored when full, pop when empty.
module chan_fifo2
    import arbitrated_channel_mux_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_head,
    output fifo_cnt_t         o_count,
    output logic              o_full
);

    logic [DATA_W-1:0] r_mem0;
    logic [DATA_W-1:0] r_mem1;
    fifo_cnt_t         r_count;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == fifo_cnt_t'(CHAN_FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~w_empty;
    assign o_head  = r_mem0;
    assign o_count = r_count;

    // Storage and occupancy update; head stays in r_mem0 so order is kept on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem0  <= '0;
            r_mem1  <= '0;
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == '0) r_mem0 <= i_data;
                    else               r_mem1 <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_mem0  <= r_mem1;
                    r_count <= r_count - 2'd1;
                end
                // Both active implies count == 1: new beat replaces the departing head.
                2'b11:   r_mem0 <= i_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/arbitrated_channel_mux.sv
// arbitrated_channel_mux: N buffered channels funnelled into one registered
// valid/ready stream. A rotating one-hot token marks the lowest-priority
// channel, which is never granted while it holds the token.
module arbitrated_channel_mux
    import arbitrated_channel_mux_pkg::*;
#(
    parameter int unsigned N                = 8,
    parameter int unsigned DATA_W           = 32,
    parameter int unsigned INIT_LOWEST_PRIO = N - 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [N*DATA_W-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [$clog2(N)-1:0] out_src
);

    localparam int unsigned    SRC_W    = $clog2(N);
    localparam logic [N-1:0]   TOK_INIT = N'(1) << INIT_LOWEST_PRIO;

    logic [N-1:0]      w_full;
    logic [N-1:0]      w_req;
    logic [N-1:0]      w_elig;
    logic [N-1:0]      w_pop;
    logic [DATA_W-1:0] w_head [N];
    fifo_cnt_t         w_count [N];
    logic [SRC_W-1:0]  w_tok_pos;
    logic [SRC_W-1:0]  w_grant;
    logic              w_found;
    logic              w_load;
    int unsigned       w_idx;

    logic [N-1:0]      r_tok;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [SRC_W-1:0]  r_out_src;

    for (genvar g = 0; g < N; g++) begin : g_chan
        chan_fifo2 #(.DATA_W(DATA_W)) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (in_valid[g] & ~w_full[g]),
            .i_pop   (w_pop[g]),
            .i_data  (in_data[g*DATA_W +: DATA_W]),
            .o_head  (w_head[g]),
            .o_count (w_count[g]),
            .o_full  (w_full[g])
        );
        assign in_ready[g] = ~w_full[g];
        assign w_req[g]    = (w_count[g] != '0);
    end

    assign w_elig = w_req & ~r_tok;

    // Binary position of the one-hot token.
    always_comb begin
        w_tok_pos = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (r_tok[i]) w_tok_pos = SRC_W'(i);
        end
    end

    // Cyclic search for the first eligible channel after the token position.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        for (int unsigned k = 1; k < N; k++) begin
            w_idx = 32'(w_tok_pos) + k;
            if (w_idx >= N) w_idx = w_idx - N;
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_grant = SRC_W'(w_idx);
            end
        end
    end

    assign w_load = w_found & (~r_out_valid | out_ready);
    assign w_pop  = w_load ? (N'(1) << w_grant) : '0;

    // Output register: load the granted head, or drain after a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_head[w_grant];
            r_out_src   <= w_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Token advances on every load, or when the excluded channel is the only requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tok <= TOK_INIT;
        end else if (w_load || (w_req == r_tok)) begin
            r_tok <= {r_tok[N-2:0], r_tok[N-1]};
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule
